fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset; bits [1:0] SHALL be zero.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port resetN, input, 1, asynchronous active-low reset.
REQ-005 Port imemReq, output, 1, instruction-memory request.
REQ-006 Port imemAddr, output, 32, fetch address, word-aligned.
REQ-007 Port imemAck, input, 1, memory returns imemData this cycle.
REQ-008 Port imemData, input, 32, fetched instruction word.
REQ-009 Port stall, input, 1, decode cannot accept; hold the IF/ID contents.
REQ-010 Port redirect, input, 1, taken branch or jump; flush and refetch.
REQ-011 Port redirectPc, input, 32, redirect target; bits [1:0] ignored and forced to 00.
REQ-012 Port instr, output, 32, IF/ID instruction register.
REQ-013 Port opCode, output, 6, instr[31:26], feeds the main control decoder.
REQ-014 Port pcPlus4, output, 32, IF/ID PC+4 of instr.
REQ-015 Port instrValid, output, 1, instr/pcPlus4 hold a live instruction.

Function
REQ-016 FSM states SHALL be IDLE, REQ, HOLD and DROP; state SHALL be registered.
REQ-017 IDLE SHALL drive imemReq=0 and go to REQ on the next clock.
REQ-018 REQ SHALL drive imemReq=1 with imemAddr held from a reqAddr register.
REQ-019 imemReq and imemAddr SHALL stay stable from assertion until the imemAck cycle.
REQ-020 REQ with imemAck and !stall SHALL load instr<=imemData, pcPlus4<=reqAddr+4 and instrValid<=1, then issue the next request for reqAddr+4 on the next cycle, giving 1 instruction/cycle throughput.
REQ-021 REQ with imemAck and stall SHALL capture the data and PC+4 in the skid buffer, leave IF/ID unchanged, and go to HOLD.
REQ-022 REQ without imemAck and with !stall SHALL set instrValid<=0 (bubble).
REQ-023 Any state with stall and no redirect SHALL hold IF/ID unchanged.
REQ-024 HOLD SHALL drive imemReq=0; when !stall, it SHALL move the skid buffer to IF/ID, set instrValid=1, and go to REQ with reqAddr = skid PC+4.
REQ-025 Redirect priority: redirect SHALL beat stall and imemAck, and it SHALL force instrValid<=0 the next cycle.
REQ-026 Redirect in IDLE or HOLD, or in REQ in the same cycle as imemAck, SHALL discard pending data and the skid buffer, and the next request SHALL be to redirectPc.
REQ-027 Redirect in REQ without imemAck SHALL latch redirectPc into pendPc and go to DROP; imemReq/imemAddr SHALL stay unchanged.
REQ-028 DROP SHALL keep the outstanding request until imemAck, discard that data, and then go to REQ with reqAddr=pendPc.
REQ-029 A further redirect in DROP SHALL overwrite pendPc; a redirect coinciding with the DROP ack SHALL use the new target.
REQ-030 PC arithmetic SHALL be modulo 2^32: reqAddr 32'hFFFF_FFFC +4 wraps to 0.
REQ-031 At most one request SHALL be outstanding at any time.

Reset
REQ-032 While resetN=0, outputs SHALL be: state=IDLE, imemReq=0, imemAddr=RESET_PC, instr=0, opCode=0, pcPlus4=0, instrValid=0.
REQ-033 Reset asserted mid-request SHALL abandon the request immediately; the memory side tolerates a dropped request.

Configuration
REQ-034 With FETCH_PERF_CNT_EN defined, the block SHALL add 32-bit outputs fetchCount and flushCount.
REQ-035 fetchCount SHALL increment per instruction delivered to IF/ID, and flushCount SHALL increment per redirect cycle.
REQ-036 Both counters SHALL reset to 0 and wrap at 2^32.
REQ-037 Without FETCH_PERF_CNT_EN, neither port nor the counter logic SHALL exist.

Structure
REQ-038 Shared package mips_pkg SHALL hold the fetch state enum, OPCODE_W=6, XLEN=32 and the RESET_PC default.
REQ-039 Sub-module fetch_skid SHALL be a one-entry buffer holding {instr, pcPlus4, valid}, with load/unload/clear inputs.

Verification
REQ-040 Reset release with imemAck tied high SHALL give imemAddr 0,4,8; instrValid high from cycle 3; opCode = imemData[31:26].
REQ-041 stall high for 3 cycles on an ack of addr 0x10 SHALL hold IF/ID at addr 0x0C, buffer 0x10, and deliver 0x10 then request 0x14 after stall drops.
REQ-042 redirect to 0x400 with an ack in the same cycle SHALL discard that data, make the next imemAddr 0x400, and give instrValid=0 for 1 cycle.
REQ-043 redirect to 0x400 while the request for 0x20 waits 4 cycles SHALL keep imemAddr=0x20 until ack, drop the data, then make imemAddr 0x400.
REQ-044 redirectPc 32'hFFFF_FFFE SHALL request 0xFFFF_FFFC, and the next request SHALL be 0x0.
REQ-045 resetN low during DROP SHALL give imemReq=0 immediately and, after release, the first address RESET_PC; with the macro defined, counters SHALL read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types, widths and reset PC
package mips_pkg;
  localparam int XLEN = 32;
  localparam int OPCODE_W = 6;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer for an instruction acked while decode is stalled
module fetch_skid
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc4_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc4,
  output logic            valid
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr <= '0;
      pc4 <= '0;
      valid <= 1'b0;
    end else if (clear) valid <= 1'b0;
    else if (load) begin
      instr <= instr_in;
      pc4 <= pc4_in;
      valid <= 1'b1;
    end else if (unload) valid <= 1'b0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with skid buffer and redirect drop; FETCH_PERF_CNT_EN adds fetchCount/flushCount
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                clk,
  input  logic                resetN,
  output logic                imemReq,
  output logic [XLEN-1:0]     imemAddr,
  input  logic                imemAck,
  input  logic [XLEN-1:0]     imemData,
  input  logic                stall,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirectPc,
  output logic [XLEN-1:0]     instr,
  output logic [OPCODE_W-1:0] opCode,
  output logic [XLEN-1:0]     pcPlus4,
  output logic                instrValid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]     fetchCount,
  output logic [XLEN-1:0]     flushCount
`endif
);
  fetch_state_t state;
  logic [XLEN-1:0] req_addr, pend_pc, tgt, skid_instr, skid_pc4;
  logic skid_valid, skid_load, skid_unload;
  assign tgt = redirectPc & ~32'd3;
  assign imemAddr = req_addr;
  assign opCode = instr[XLEN-1 -: OPCODE_W];
  assign skid_load = state == REQ && imemAck && stall && !redirect;
  assign skid_unload = state == HOLD && !stall && !redirect;
  fetch_skid u_skid (
    .clk(clk),
    .rst_n(resetN),
    .load(skid_load),
    .unload(skid_unload),
    .clear(redirect),
    .instr_in(imemData),
    .pc4_in(req_addr + 32'd4),
    .instr(skid_instr),
    .pc4(skid_pc4),
    .valid(skid_valid)
  );
  // Redirect outranks stall and ack; an un-acked request must drain in DROP first
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      imemReq <= 1'b0;
      req_addr <= RESET_PC;
      pend_pc <= RESET_PC;
      instr <= '0;
      pcPlus4 <= '0;
      instrValid <= 1'b0;
    end else if (redirect) begin
      instrValid <= 1'b0;
      if ((state == REQ || state == DROP) && !imemAck) begin
        state <= DROP;
        pend_pc <= tgt;
      end else begin
        state <= REQ;
        imemReq <= 1'b1;
        req_addr <= tgt;
      end
    end else
      case (state)
        IDLE: begin
          state <= REQ;
          imemReq <= 1'b1;
        end
        REQ:
          if (imemAck && !stall) begin
            instr <= imemData;
            pcPlus4 <= req_addr + 32'd4;
            instrValid <= 1'b1;
            req_addr <= req_addr + 32'd4;
          end else if (imemAck) begin
            state <= HOLD;
            imemReq <= 1'b0;
          end else if (!stall) instrValid <= 1'b0;
        HOLD:
          if (!stall) begin
            instr <= skid_instr;
            pcPlus4 <= skid_pc4;
            instrValid <= skid_valid;
            req_addr <= skid_pc4;
            state <= REQ;
            imemReq <= 1'b1;
          end
        default: begin
          if (imemAck) begin
            state <= REQ;
            req_addr <= pend_pc;
          end
          if (!stall) instrValid <= 1'b0;
        end
      endcase
`ifdef FETCH_PERF_CNT_EN
  logic deliver;
  assign deliver = skid_unload || (state == REQ && imemAck && !stall && !redirect);
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      fetchCount <= '0;
      flushCount <= '0;
    end else begin
      fetchCount <= fetchCount + {31'd0, deliver};
      flushCount <= flushCount + {31'd0, redirect};
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus reset-in-DROP sequence for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0, resetN = 1'b0, imemReq, imemAck = 1'b0, stall = 1'b0, redirect = 1'b0, instrValid;
  logic [31:0] imemAddr, imemData, redirectPc = '0, instr, pcPlus4;
  logic [5:0] opCode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCount, flushCount;
`endif
  int cmp = 0, errs = 0;
  always #5 clk = ~clk;
  assign imemData = ~imemAddr;
  fetch_unit dut (
    .clk(clk),
    .resetN(resetN),
    .imemReq(imemReq),
    .imemAddr(imemAddr),
    .imemAck(imemAck),
    .imemData(imemData),
    .stall(stall),
    .redirect(redirect),
    .redirectPc(redirectPc),
    .instr(instr),
    .opCode(opCode),
    .pcPlus4(pcPlus4),
    .instrValid(instrValid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetchCount(fetchCount),
    .flushCount(flushCount)
`endif
  );
  // ctl = {ack, stall, redirect}; ex = {imemReq, instrValid, delivered}
  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] rpc;
    logic [2:0]  ex;
    logic [31:0] addr;
    logic [31:0] pc4;
  } vec_t;
  vec_t tbl[32];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int exp_fetch, exp_flush;
    logic [31:0] ei;
    exp_fetch = 0;
    exp_flush = 0;
    tbl[0]  = '{3'b100, 32'h0, 3'b100, 32'h0, 32'h0};
    tbl[1]  = '{3'b100, 32'h0, 3'b111, 32'h4, 32'h4};
    tbl[2]  = '{3'b100, 32'h0, 3'b111, 32'h8, 32'h8};
    tbl[3]  = '{3'b100, 32'h0, 3'b111, 32'hC, 32'hC};
    tbl[4]  = '{3'b100, 32'h0, 3'b111, 32'h10, 32'h10};
    tbl[5]  = '{3'b110, 32'h0, 3'b010, 32'h10, 32'h10};
    tbl[6]  = '{3'b010, 32'h0, 3'b010, 32'h10, 32'h10};
    tbl[7]  = '{3'b010, 32'h0, 3'b010, 32'h10, 32'h10};
    tbl[8]  = '{3'b000, 32'h0, 3'b111, 32'h14, 32'h14};
    tbl[9]  = '{3'b000, 32'h0, 3'b100, 32'h14, 32'h14};
    tbl[10] = '{3'b100, 32'h0, 3'b111, 32'h18, 32'h18};
    tbl[11] = '{3'b100, 32'h0, 3'b111, 32'h1C, 32'h1C};
    tbl[12] = '{3'b100, 32'h0, 3'b111, 32'h20, 32'h20};
    tbl[13] = '{3'b001, 32'h400, 3'b100, 32'h20, 32'h20};
    tbl[14] = '{3'b000, 32'h0, 3'b100, 32'h20, 32'h20};
    tbl[15] = '{3'b000, 32'h0, 3'b100, 32'h20, 32'h20};
    tbl[16] = '{3'b100, 32'h0, 3'b100, 32'h400, 32'h20};
    tbl[17] = '{3'b100, 32'h0, 3'b111, 32'h404, 32'h404};
    tbl[18] = '{3'b101, 32'h400, 3'b100, 32'h400, 32'h404};
    tbl[19] = '{3'b100, 32'h0, 3'b111, 32'h404, 32'h404};
    tbl[20] = '{3'b101, 32'hFFFF_FFFE, 3'b100, 32'hFFFF_FFFC, 32'h404};
    tbl[21] = '{3'b100, 32'h0, 3'b111, 32'h0, 32'h0};
    tbl[22] = '{3'b100, 32'h0, 3'b111, 32'h4, 32'h4};
    tbl[23] = '{3'b110, 32'h0, 3'b010, 32'h4, 32'h4};
    tbl[24] = '{3'b011, 32'h83, 3'b100, 32'h80, 32'h4};
    tbl[25] = '{3'b100, 32'h0, 3'b111, 32'h84, 32'h84};
    tbl[26] = '{3'b001, 32'h200, 3'b100, 32'h84, 32'h84};
    tbl[27] = '{3'b001, 32'h300, 3'b100, 32'h84, 32'h84};
    tbl[28] = '{3'b101, 32'h500, 3'b100, 32'h500, 32'h84};
    tbl[29] = '{3'b100, 32'h0, 3'b111, 32'h504, 32'h504};
    tbl[30] = '{3'b010, 32'h0, 3'b110, 32'h504, 32'h504};
    tbl[31] = '{3'b100, 32'h0, 3'b111, 32'h508, 32'h508};
    repeat (2) @(posedge clk);
    #1;
    chk("rst imemReq", {31'd0, imemReq}, 32'd0);
    chk("rst imemAddr", imemAddr, 32'h0);
    chk("rst instr", instr, 32'h0);
    chk("rst opCode", {26'd0, opCode}, 32'd0);
    chk("rst pcPlus4", pcPlus4, 32'h0);
    chk("rst instrValid", {31'd0, instrValid}, 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 32; i++) begin
      {imemAck, stall, redirect} = tbl[i].ctl;
      redirectPc = tbl[i].rpc;
      exp_fetch += int'(tbl[i].ex[0]);
      exp_flush += int'(tbl[i].ctl[0]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d imemReq", i), {31'd0, imemReq}, {31'd0, tbl[i].ex[2]});
      chk($sformatf("v%0d imemAddr", i), imemAddr, tbl[i].addr);
      chk($sformatf("v%0d instrValid", i), {31'd0, instrValid}, {31'd0, tbl[i].ex[1]});
      chk($sformatf("v%0d pcPlus4", i), pcPlus4, tbl[i].pc4);
      if (tbl[i].ex[1]) begin
        ei = ~(tbl[i].pc4 - 32'd4);
        chk($sformatf("v%0d instr", i), instr, ei);
        chk($sformatf("v%0d opCode", i), {26'd0, opCode}, {26'd0, ei[31:26]});
      end
      @(negedge clk);
    end
    {imemAck, stall, redirect} = 3'b001;
    redirectPc = 32'h600;
    exp_flush++;
    @(posedge clk);
    #1;
    chk("drop imemReq", {31'd0, imemReq}, 32'd1);
    chk("drop imemAddr", imemAddr, 32'h508);
    chk("drop instrValid", {31'd0, instrValid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("fetchCount", fetchCount, exp_fetch);
    chk("flushCount", flushCount, exp_flush);
`endif
    @(negedge clk);
    #2;
    resetN = 1'b0;
    #1;
    chk("rst-drop imemReq", {31'd0, imemReq}, 32'd0);
    chk("rst-drop imemAddr", imemAddr, 32'h0);
    chk("rst-drop instrValid", {31'd0, instrValid}, 32'd0);
    chk("rst-drop pcPlus4", pcPlus4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst fetchCount", fetchCount, 32'd0);
    chk("rst flushCount", flushCount, 32'd0);
`endif
    {imemAck, stall, redirect} = 3'b100;
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst imemReq", {31'd0, imemReq}, 32'd1);
    chk("post-rst imemAddr", imemAddr, 32'h0);
    chk("post-rst instrValid", {31'd0, instrValid}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
